// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl shared types: MIPS opcodes, control bundle,
// PC-source and forwarding select encodings.
package pipe_ctrl_pkg;

  localparam logic [5:0] R_TYPE = 6'h00;
  localparam logic [5:0] LW     = 6'h23;
  localparam logic [5:0] SW     = 6'h2B;
  localparam logic [5:0] ADDI   = 6'h08;
  localparam logic [5:0] ANDI   = 6'h0C;
  localparam logic [5:0] BEQ    = 6'h04;
  localparam logic [5:0] BNE    = 6'h05;
  localparam logic [5:0] J      = 6'h02;
  localparam logic [5:0] JAL    = 6'h03;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10
  } pc_src_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_e;

  typedef struct packed {
    logic       alu_src;
    logic [1:0] alu_case;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic       branch_eq;
    logic       branch_ne;
    logic       jump;
  } ctrl_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl bundle: ID fields and EX flag in,
// stall/flush/select/strobe controls out.
interface pipe_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int OP_W   = 6
);
  logic [OP_W-1:0]   id_opcode;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic              ex_zero;
  logic              pc_write;
  logic              if_id_write;
  logic              if_id_flush;
  logic [1:0]        pc_src;
  logic              ex_alu_src;
  logic [1:0]        ex_alu_case;
  logic [1:0]        forward_a;
  logic [1:0]        forward_b;
  logic              mem_read;
  logic              mem_write;
  logic              wb_reg_write;
  logic [1:0]        wb_mem_to_reg;
  logic [REG_AW-1:0] wb_dest;

  modport master (
    output id_opcode, id_rs, id_rt, id_rd, ex_zero,
    input  pc_write, if_id_write, if_id_flush, pc_src,
    input  ex_alu_src, ex_alu_case, forward_a, forward_b,
    input  mem_read, mem_write,
    input  wb_reg_write, wb_mem_to_reg, wb_dest
  );

  modport slave (
    input  id_opcode, id_rs, id_rt, id_rd, ex_zero,
    output pc_write, if_id_write, if_id_flush, pc_src,
    output ex_alu_src, ex_alu_case, forward_a, forward_b,
    output mem_read, mem_write,
    output wb_reg_write, wb_mem_to_reg, wb_dest
  );
endinterface

// File: rtl/pipe_ctrl_hazard_fwd_unit.sv
// hazard_fwd_unit: load-use detection and EX operand
// forwarding selects; purely combinational.
module hazard_fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              use_rs,
  input  logic              use_rt,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_dest,
  output logic              load_use,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b
);

  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] src,
    input logic              m_we,
    input logic [REG_AW-1:0] m_dst,
    input logic              w_we,
    input logic [REG_AW-1:0] w_dst
  );
    if (m_we && m_dst != '0 && m_dst == src)
      return FWD_MEM;
    if (w_we && w_dst != '0 && w_dst == src)
      return FWD_WB;
    return FWD_RF;
  endfunction

  // stall when a load in EX feeds a source used in ID
  always_comb begin
    load_use = 1'b0;
    if (ex_mem_read && ex_dest != '0)
      load_use = (use_rs && ex_dest == id_rs) ||
                 (use_rt && ex_dest == id_rt);
  end

  // youngest producer wins; $0 never forwards
  always_comb begin
    forward_a = fwd_sel(ex_rs, mem_reg_write, mem_dest,
                        wb_reg_write, wb_dest);
    forward_b = fwd_sel(ex_rt, mem_reg_write, mem_dest,
                        wb_reg_write, wb_dest);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: ID decode, ID/EX, EX/MEM, MEM/WB control
// registers and branch/stall/jump priority.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int OP_W   = 6,
  parameter int RA_REG = 31
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);

  typedef struct packed {
    logic              alu_src;
    logic [1:0]        alu_case;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic [1:0]        mem_to_reg;
    logic              branch_eq;
    logic              branch_ne;
    logic [REG_AW-1:0] dest;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
  } id_ex_t;

  typedef struct packed {
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic [1:0]        mem_to_reg;
    logic [REG_AW-1:0] dest;
  } ex_mem_t;

  typedef struct packed {
    logic              reg_write;
    logic [1:0]        mem_to_reg;
    logic [REG_AW-1:0] dest;
  } mem_wb_t;

  logic [OP_W-1:0]   op;
  ctrl_t             id_ctrl;
  logic [REG_AW-1:0] id_dest;
  logic              use_rs;
  logic              use_rt;
  id_ex_t            id_ex_d;
  id_ex_t            id_ex_q;
  ex_mem_t           ex_mem_q;
  mem_wb_t           mem_wb_q;
  logic              taken;
  logic              load_use;
  logic              bubble;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;

  assign op = bus.id_opcode;

  // decode ID opcode into control bundle and source use
  always_comb begin
    id_ctrl = '0;
    id_dest = '0;
    use_rs  = 1'b0;
    use_rt  = 1'b0;
    unique case (op)
      R_TYPE: begin
        id_ctrl.alu_case  = 2'b10;
        id_ctrl.reg_write = 1'b1;
        id_dest = bus.id_rd;
        use_rs  = 1'b1;
        use_rt  = 1'b1;
      end
      LW: begin
        id_ctrl.alu_src    = 1'b1;
        id_ctrl.mem_read   = 1'b1;
        id_ctrl.reg_write  = 1'b1;
        id_ctrl.mem_to_reg = 2'b01;
        id_dest = bus.id_rt;
        use_rs  = 1'b1;
      end
      SW: begin
        id_ctrl.alu_src   = 1'b1;
        id_ctrl.mem_write = 1'b1;
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      ADDI: begin
        id_ctrl.alu_src   = 1'b1;
        id_ctrl.reg_write = 1'b1;
        id_dest = bus.id_rt;
        use_rs  = 1'b1;
      end
      ANDI: begin
        id_ctrl.alu_case  = 2'b11;
        id_ctrl.alu_src   = 1'b1;
        id_ctrl.reg_write = 1'b1;
        id_dest = bus.id_rt;
        use_rs  = 1'b1;
      end
      BEQ: begin
        id_ctrl.alu_case  = 2'b01;
        id_ctrl.branch_eq = 1'b1;
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      BNE: begin
        id_ctrl.alu_case  = 2'b01;
        id_ctrl.branch_ne = 1'b1;
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      J: begin
        id_ctrl.jump = 1'b1;
      end
      JAL: begin
        id_ctrl.jump       = 1'b1;
        id_ctrl.reg_write  = 1'b1;
        id_ctrl.mem_to_reg = 2'b10;
        id_dest = REG_AW'(RA_REG);
      end
      default: ;
    endcase
  end

  hazard_fwd_unit #(.REG_AW(REG_AW)) u_hfu (
    .ex_mem_read   (id_ex_q.mem_read),
    .ex_dest       (id_ex_q.dest),
    .ex_rs         (id_ex_q.rs),
    .ex_rt         (id_ex_q.rt),
    .id_rs         (bus.id_rs),
    .id_rt         (bus.id_rt),
    .use_rs        (use_rs),
    .use_rt        (use_rt),
    .mem_reg_write (ex_mem_q.reg_write),
    .mem_dest      (ex_mem_q.dest),
    .wb_reg_write  (mem_wb_q.reg_write),
    .wb_dest       (mem_wb_q.dest),
    .load_use      (load_use),
    .forward_a     (fwd_a),
    .forward_b     (fwd_b)
  );

  assign taken  = (id_ex_q.branch_eq & bus.ex_zero) |
                  (id_ex_q.branch_ne & ~bus.ex_zero);
  assign bubble = taken | load_use;

  // taken branch beats stall beats jump
  always_comb begin
    bus.pc_write    = 1'b1;
    bus.if_id_write = 1'b1;
    bus.if_id_flush = 1'b0;
    bus.pc_src      = PC_PLUS4;
    if (taken) begin
      bus.pc_src      = PC_BRANCH;
      bus.if_id_flush = 1'b1;
    end else if (load_use) begin
      bus.pc_write    = 1'b0;
      bus.if_id_write = 1'b0;
    end else if (id_ctrl.jump) begin
      bus.pc_src      = PC_JUMP;
      bus.if_id_flush = 1'b1;
    end
  end

  // next ID/EX: decoded bundle or a bubble
  always_comb begin
    id_ex_d = '0;
    if (!bubble) begin
      id_ex_d.alu_src    = id_ctrl.alu_src;
      id_ex_d.alu_case   = id_ctrl.alu_case;
      id_ex_d.mem_read   = id_ctrl.mem_read;
      id_ex_d.mem_write  = id_ctrl.mem_write;
      id_ex_d.reg_write  = id_ctrl.reg_write;
      id_ex_d.mem_to_reg = id_ctrl.mem_to_reg;
      id_ex_d.branch_eq  = id_ctrl.branch_eq;
      id_ex_d.branch_ne  = id_ctrl.branch_ne;
      id_ex_d.dest       = id_dest;
      id_ex_d.rs         = bus.id_rs;
      id_ex_d.rt         = bus.id_rt;
    end
  end

  // advance the three control pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      id_ex_q             <= id_ex_d;
      ex_mem_q.mem_read   <= id_ex_q.mem_read;
      ex_mem_q.mem_write  <= id_ex_q.mem_write;
      ex_mem_q.reg_write  <= id_ex_q.reg_write;
      ex_mem_q.mem_to_reg <= id_ex_q.mem_to_reg;
      ex_mem_q.dest       <= id_ex_q.dest;
      mem_wb_q.reg_write  <= ex_mem_q.reg_write;
      mem_wb_q.mem_to_reg <= ex_mem_q.mem_to_reg;
      mem_wb_q.dest       <= ex_mem_q.dest;
    end
  end

  assign bus.forward_a     = fwd_a;
  assign bus.forward_b     = fwd_b;
  assign bus.ex_alu_src    = id_ex_q.alu_src;
  assign bus.ex_alu_case   = id_ex_q.alu_case;
  assign bus.mem_read      = ex_mem_q.mem_read;
  assign bus.mem_write     = ex_mem_q.mem_write;
  assign bus.wb_reg_write  = mem_wb_q.reg_write;
  assign bus.wb_mem_to_reg = mem_wb_q.mem_to_reg;
  assign bus.wb_dest       = mem_wb_q.dest;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: instruction-stream model of the pipeline
// compared against pipe_ctrl every cycle, plus directed pins.
module tb_pipe_ctrl;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_NOP  = 6'b111111;

  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       zf;
  } ins_t;

  function automatic ins_t mk(input logic [5:0] op,
                              input int rs, input int rt,
                              input int rd, input bit zf);
    ins_t i;
    i.op = op;
    i.rs = 5'(rs);
    i.rt = 5'(rt);
    i.rd = 5'(rd);
    i.zf = zf;
    return i;
  endfunction

  localparam ins_t NOP_I = '{op: 6'b111111, rs: 5'd0,
                             rt: 5'd0, rd: 5'd0, zf: 1'b0};

  function automatic bit wr(input logic [5:0] op);
    return op inside {OP_R, OP_LW, OP_ADDI, OP_ANDI, OP_JAL};
  endfunction

  function automatic logic [4:0] dst(input ins_t i);
    if (i.op == OP_R) return i.rd;
    if (i.op inside {OP_LW, OP_ADDI, OP_ANDI}) return i.rt;
    if (i.op == OP_JAL) return 5'd31;
    return 5'd0;
  endfunction

  function automatic bit rd_rs(input logic [5:0] op);
    return op inside {OP_R, OP_LW, OP_SW, OP_ADDI,
                      OP_ANDI, OP_BEQ, OP_BNE};
  endfunction

  function automatic bit rd_rt(input logic [5:0] op);
    return op inside {OP_R, OP_SW, OP_BEQ, OP_BNE};
  endfunction

  logic clk;
  logic rst;
  bit   chk_en;
  int   n_vec;
  int   n_err;

  pipe_ctrl_if #(.REG_AW(5), .OP_W(6)) bus ();

  pipe_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ins_t m_id, m_ex, m_mem, m_wb;
  ins_t prog[$];
  int   f;

  function automatic logic [1:0] fwd(input logic [4:0] r);
    if (wr(m_mem.op) && dst(m_mem) != 0 && dst(m_mem) == r)
      return 2'b10;
    if (wr(m_wb.op) && dst(m_wb) != 0 && dst(m_wb) == r)
      return 2'b01;
    return 2'b00;
  endfunction

  bit         m_tk, m_lu, m_jp;
  logic       e_pcw, e_flush, e_asrc;
  logic [1:0] e_pcsrc, e_case, e_fa, e_fb, e_m2r;
  logic [4:0] e_dest;

  always_comb begin
    m_tk = (m_ex.op == OP_BEQ && m_ex.zf) ||
           (m_ex.op == OP_BNE && !m_ex.zf);
    m_lu = m_ex.op == OP_LW && dst(m_ex) != 0 &&
           ((rd_rs(m_id.op) && dst(m_ex) == m_id.rs) ||
            (rd_rt(m_id.op) && dst(m_ex) == m_id.rt));
    m_jp = m_id.op inside {OP_J, OP_JAL};
    e_pcw   = m_tk || !m_lu;
    e_flush = m_tk || (!m_lu && m_jp);
    e_pcsrc = m_tk ? 2'b01 : (m_lu ? 2'b00 :
              (m_jp ? 2'b10 : 2'b00));
    e_fa    = fwd(m_ex.rs);
    e_fb    = fwd(m_ex.rt);
    e_asrc  = m_ex.op inside {OP_LW, OP_SW, OP_ADDI, OP_ANDI};
    e_case  = 2'b00;
    if (m_ex.op == OP_R) e_case = 2'b10;
    if (m_ex.op == OP_ANDI) e_case = 2'b11;
    if (m_ex.op inside {OP_BEQ, OP_BNE}) e_case = 2'b01;
    e_m2r = 2'b00;
    if (m_wb.op == OP_LW) e_m2r = 2'b01;
    if (m_wb.op == OP_JAL) e_m2r = 2'b10;
    e_dest = dst(m_wb);
  end

  task automatic chk(input string name,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h",
               name, $time, act, exp);
    end
  endtask

  // one compare against the model every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc_write", 8'(bus.pc_write), 8'(e_pcw));
      chk("if_id_write", 8'(bus.if_id_write), 8'(e_pcw));
      chk("if_id_flush", 8'(bus.if_id_flush), 8'(e_flush));
      chk("pc_src", 8'(bus.pc_src), 8'(e_pcsrc));
      chk("forward_a", 8'(bus.forward_a), 8'(e_fa));
      chk("forward_b", 8'(bus.forward_b), 8'(e_fb));
      chk("ex_alu_src", 8'(bus.ex_alu_src), 8'(e_asrc));
      chk("ex_alu_case", 8'(bus.ex_alu_case), 8'(e_case));
      chk("mem_read", 8'(bus.mem_read),
          8'(m_mem.op == OP_LW));
      chk("mem_write", 8'(bus.mem_write),
          8'(m_mem.op == OP_SW));
      chk("wb_reg_write", 8'(bus.wb_reg_write),
          8'(wr(m_wb.op)));
      chk("wb_mem_to_reg", 8'(bus.wb_mem_to_reg), 8'(e_m2r));
      chk("wb_dest", 8'(bus.wb_dest), 8'(e_dest));
    end
  end

  function automatic ins_t fetch(input int k);
    if (k < prog.size()) return prog[k];
    return NOP_I;
  endfunction

  task automatic update();
    bit tk, lu, jp;
    tk = m_tk;
    lu = m_lu;
    jp = m_jp;
    if (rst) begin
      m_id = NOP_I; m_ex = NOP_I;
      m_mem = NOP_I; m_wb = NOP_I;
      f = 0;
    end else begin
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ex  = (tk || lu) ? NOP_I : m_id;
      if (tk || jp) begin
        m_id = NOP_I;
        f++;
      end else if (!lu) begin
        m_id = fetch(f);
        f++;
      end
    end
  endtask

  task automatic drive();
    bus.id_opcode = m_id.op;
    bus.id_rs     = m_id.rs;
    bus.id_rt     = m_id.rt;
    bus.id_rd     = m_id.rd;
    bus.ex_zero   = m_ex.zf;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    update();
    drive();
    #2;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    chk_en = 1'b0;
    rst = 1'b1;
    m_id = NOP_I; m_ex = NOP_I;
    m_mem = NOP_I; m_wb = NOP_I;
    f = 0;
    drive();

    // reset, NOP stream, load-use
    prog = {NOP_I, NOP_I,
            mk(OP_LW, 1, 2, 0, 0),
            mk(OP_R, 2, 4, 3, 0)};
    do_reset();
    chk("rst_pc_write", 8'(bus.pc_write), 8'd1);
    chk("rst_if_id_write", 8'(bus.if_id_write), 8'd1);
    chk("rst_flush", 8'(bus.if_id_flush), 8'd0);
    chk("rst_pc_src", 8'(bus.pc_src), 8'd0);
    chk("rst_fwd_a", 8'(bus.forward_a), 8'd0);
    chk("rst_mem_write", 8'(bus.mem_write), 8'd0);
    chk("rst_wb_reg_write", 8'(bus.wb_reg_write), 8'd0);
    chk("rst_wb_dest", 8'(bus.wb_dest), 8'd0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("nop_mem_read", 8'(bus.mem_read), 8'd0);
      chk("nop_mem_write", 8'(bus.mem_write), 8'd0);
    end
    step();
    chk("lu_pc_write", 8'(bus.pc_write), 8'd0);
    chk("lu_if_id_write", 8'(bus.if_id_write), 8'd0);
    step();
    chk("lu_bubble_alu_src", 8'(bus.ex_alu_src), 8'd0);
    chk("lu_once_pc_write", 8'(bus.pc_write), 8'd1);
    step();
    chk("lu_fwd_a", 8'(bus.forward_a), 8'd1);
    chk("lu_fwd_b", 8'(bus.forward_b), 8'd0);
    chk("lu_alu_case", 8'(bus.ex_alu_case), 8'd2);
    steps(3);

    // forwarding, $0 destinations, double producer
    prog = {mk(OP_ADDI, 0, 5, 0, 0),
            mk(OP_ADDI, 0, 6, 0, 0),
            mk(OP_R, 5, 6, 7, 0),
            mk(OP_ADDI, 0, 0, 0, 0),
            mk(OP_ADDI, 0, 0, 0, 0),
            mk(OP_R, 0, 0, 9, 0),
            mk(OP_ADDI, 0, 10, 0, 0),
            mk(OP_ANDI, 0, 10, 0, 0),
            mk(OP_R, 10, 10, 11, 0)};
    do_reset();
    steps(4);
    chk("fw_a_wb", 8'(bus.forward_a), 8'd1);
    chk("fw_b_mem", 8'(bus.forward_b), 8'd2);
    steps(3);
    chk("fw_r0_a", 8'(bus.forward_a), 8'd0);
    chk("fw_r0_b", 8'(bus.forward_b), 8'd0);
    steps(3);
    chk("fw_both_a", 8'(bus.forward_a), 8'd2);
    chk("fw_both_b", 8'(bus.forward_b), 8'd2);
    steps(4);

    // BEQ taken squashes two, BNE with zero not taken
    prog = {mk(OP_ADDI, 0, 1, 0, 0),
            mk(OP_BEQ, 1, 1, 0, 1),
            mk(OP_SW, 2, 1, 0, 0),
            mk(OP_ADDI, 0, 9, 0, 0),
            NOP_I,
            mk(OP_BNE, 3, 4, 0, 1),
            mk(OP_SW, 5, 6, 0, 0)};
    do_reset();
    steps(3);
    chk("beq_pc_src", 8'(bus.pc_src), 8'd1);
    chk("beq_flush", 8'(bus.if_id_flush), 8'd1);
    for (int c = 4; c <= 7; c++) begin
      step();
      chk("beq_sq_mem_write", 8'(bus.mem_write), 8'd0);
      if (c >= 5)
        chk("beq_sq_wb_reg_write", 8'(bus.wb_reg_write), 8'd0);
    end
    chk("bne_pc_src", 8'(bus.pc_src), 8'd0);
    chk("bne_flush", 8'(bus.if_id_flush), 8'd0);
    steps(2);
    chk("bne_sw_mem_write", 8'(bus.mem_write), 8'd1);
    steps(3);

    // JAL in ID, link write three cycles later
    prog = {NOP_I,
            mk(OP_JAL, 3, 7, 1, 0),
            mk(OP_SW, 1, 2, 0, 0)};
    do_reset();
    steps(2);
    chk("jal_pc_src", 8'(bus.pc_src), 8'd2);
    chk("jal_flush", 8'(bus.if_id_flush), 8'd1);
    steps(2);
    chk("jal_sq_mem_write4", 8'(bus.mem_write), 8'd0);
    step();
    chk("jal_sq_mem_write5", 8'(bus.mem_write), 8'd0);
    chk("jal_wb_reg_write", 8'(bus.wb_reg_write), 8'd1);
    chk("jal_wb_dest", 8'(bus.wb_dest), 8'd31);
    chk("jal_wb_m2r", 8'(bus.wb_mem_to_reg), 8'd2);
    steps(2);

    // branch wins over a would-be load-use behind it
    prog = {NOP_I,
            mk(OP_BEQ, 0, 0, 0, 1),
            mk(OP_LW, 1, 2, 0, 0),
            mk(OP_R, 2, 4, 3, 0),
            mk(OP_R, 2, 2, 5, 0)};
    do_reset();
    steps(3);
    chk("br_lu_pc_src", 8'(bus.pc_src), 8'd1);
    chk("br_lu_pc_write", 8'(bus.pc_write), 8'd1);
    chk("br_lu_if_id_write", 8'(bus.if_id_write), 8'd1);
    steps(2);
    chk("br_lu_no_stall", 8'(bus.pc_write), 8'd1);
    steps(4);

    // reset mid-stream discards SW in EX
    prog = {NOP_I, mk(OP_SW, 1, 2, 0, 0)};
    do_reset();
    steps(3);
    chk("pre_rst_alu_src", 8'(bus.ex_alu_src), 8'd1);
    rst = 1'b1;
    step();
    chk("mid_rst_mem_write", 8'(bus.mem_write), 8'd0);
    chk("mid_rst_alu_src", 8'(bus.ex_alu_src), 8'd0);
    step();
    rst = 1'b0;
    steps(3);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
